// File: rtl/uart_tx_pkg.sv
// Shared types and constants for the UART transmit feeder and byte FIFO.
package uart_tx_pkg;
  localparam int UART_DW = 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SEND = 2'd1,
    ST_GAP  = 2'd2
  } tx_state_e;
endpackage

// File: rtl/byte_fifo.sv
// Synchronous first-word-fall-through byte FIFO; read data is always mem[rd_ptr].
module byte_fifo
  import uart_tx_pkg::*;
#(
  parameter  int DEPTH = 16,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               wr_en,
  input  logic [UART_DW-1:0] wr_data,
  input  logic               rd_en,
  output logic [UART_DW-1:0] rd_data,
  output logic               full,
  output logic               empty,
  output logic [AW:0]        cnt
);
  logic [UART_DW-1:0] mem [DEPTH];
  logic [AW-1:0]      wr_ptr;
  logic [AW-1:0]      rd_ptr;
  logic               wr_ok;
  logic               rd_ok;

  // full/empty decode straight from the count register, so they reflect pre-edge occupancy
  assign full    = (cnt == (AW+1)'(DEPTH));
  assign empty   = (cnt == '0);
  assign wr_ok   = wr_en && !full;
  assign rd_ok   = rd_en && !empty;
  assign rd_data = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (wr_ok) mem[wr_ptr] <= wr_data;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (wr_ok) wr_ptr <= wr_ptr + AW'(1);
      if (rd_ok) rd_ptr <= rd_ptr + AW'(1);
      case ({wr_ok, rd_ok})
        2'b10:   cnt <= cnt + (AW+1)'(1);
        2'b01:   cnt <= cnt - (AW+1)'(1);
        default: cnt <= cnt;
      endcase
    end
  end
endmodule

// File: rtl/tx_bytes_ctrl.sv
// Multi-byte feeder for the UART byte transmitter: FIFO-buffered bytes sent one at a time
// over the TX_En_Sig/TX_Done_Sig handshake with an enforced idle gap between bytes.
//
//   state   | meaning
//   --------+-------------------------------------------------------------
//   ST_IDLE | line idle; launch next byte as soon as the FIFO is non-empty
//   ST_SEND | TX_En_Sig held high with TX_Data stable until TX_Done_Sig
//   ST_GAP  | TX_En_Sig low while gap_cnt runs down so tx_module can rearm
module tx_bytes_ctrl
  import uart_tx_pkg::*;
#(
  parameter  int DEPTH      = 16,
  parameter  int GAP_CYCLES = 2,
  localparam int AW         = $clog2(DEPTH)
) (
  input  logic               sclk,
  input  logic               RST,
  input  logic               Wr_En,
  input  logic [UART_DW-1:0] Wr_Data,
  output logic               Fifo_Full,
  output logic               Fifo_Empty,
  output logic [AW:0]        Fifo_Cnt,
  output logic               Wr_Ovf,
  output logic [UART_DW-1:0] TX_Data,
  output logic               TX_En_Sig,
  input  logic               TX_Done_Sig,
  output logic               Busy
);
  localparam int GW = ($clog2(GAP_CYCLES + 1) < 1) ? 1 : $clog2(GAP_CYCLES + 1);

  tx_state_e          state_q, state_d;
  logic [UART_DW-1:0] tx_data_d;
  logic               tx_en_d;
  logic [GW-1:0]      gap_q, gap_d;
  logic               pop;
  logic [UART_DW-1:0] rd_data;

  byte_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk     (sclk),
    .rst     (RST),
    .wr_en   (Wr_En),
    .wr_data (Wr_Data),
    .rd_en   (pop),
    .rd_data (rd_data),
    .full    (Fifo_Full),
    .empty   (Fifo_Empty),
    .cnt     (Fifo_Cnt)
  );

  always_comb begin
    state_d   = state_q;
    tx_data_d = TX_Data;
    tx_en_d   = TX_En_Sig;
    gap_d     = gap_q;
    pop       = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (!Fifo_Empty) begin
          tx_data_d = rd_data;
          tx_en_d   = 1'b1;
          pop       = 1'b1;
          state_d   = ST_SEND;
        end
      end
      ST_SEND: begin
        if (TX_Done_Sig) begin
          tx_en_d = 1'b0;
          gap_d   = GW'(GAP_CYCLES - 1);
          state_d = ST_GAP;
        end
      end
      ST_GAP: begin
        if (gap_q == '0) state_d = ST_IDLE;
        else             gap_d   = gap_q - GW'(1);
      end
      default: begin
        tx_en_d = 1'b0;
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge sclk or posedge RST) begin
    if (RST) begin
      state_q   <= ST_IDLE;
      TX_Data   <= '0;
      TX_En_Sig <= 1'b0;
      gap_q     <= '0;
      Wr_Ovf    <= 1'b0;
    end else begin
      state_q   <= state_d;
      TX_Data   <= tx_data_d;
      TX_En_Sig <= tx_en_d;
      gap_q     <= gap_d;
      // a pop in the same cycle does not rescue a write that saw a full FIFO
      Wr_Ovf    <= Wr_En && Fifo_Full;
    end
  end

  assign Busy = (state_q != ST_IDLE) || !Fifo_Empty;
endmodule

// File: tb/tb_tx_bytes_ctrl.sv
// Directed and randomized bench for tx_bytes_ctrl against a transaction-level queue model.
module tb_tx_bytes_ctrl;
  localparam int DEPTH = 16;
  localparam int GAP   = 2;
  localparam int AW    = $clog2(DEPTH);
  localparam int STUB_LAT = 10;

  logic          sclk = 1'b0;
  logic          RST;
  logic          Wr_En;
  logic [7:0]    Wr_Data;
  logic          Fifo_Full;
  logic          Fifo_Empty;
  logic [AW:0]   Fifo_Cnt;
  logic          Wr_Ovf;
  logic [7:0]    TX_Data;
  logic          TX_En_Sig;
  logic          TX_Done_Sig;
  logic          Busy;

  tx_bytes_ctrl #(.DEPTH(DEPTH), .GAP_CYCLES(GAP)) dut (
    .sclk        (sclk),
    .RST         (RST),
    .Wr_En       (Wr_En),
    .Wr_Data     (Wr_Data),
    .Fifo_Full   (Fifo_Full),
    .Fifo_Empty  (Fifo_Empty),
    .Fifo_Cnt    (Fifo_Cnt),
    .Wr_Ovf      (Wr_Ovf),
    .TX_Data     (TX_Data),
    .TX_En_Sig   (TX_En_Sig),
    .TX_Done_Sig (TX_Done_Sig),
    .Busy        (Busy)
  );

  always #5 sclk = ~sclk;

  int checks = 0;
  int failures = 0;

  // reference model: bytes waiting, byte on the line, and earliest edge a new byte may start
  logic [7:0] q[$];
  bit         on_line;
  logic [7:0] cur_byte;
  int         k;
  int         ready_at;
  bit         ovf_exp;

  int stub_cnt;
  bit hold;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s@%0d observed=%0h expected=%0h", tag, k, obs, exp);
    end
  endtask

  task automatic model_reset();
    q.delete();
    on_line  = 0;
    cur_byte = 8'h00;
    ready_at = 0;
    ovf_exp  = 0;
  endtask

  task automatic model_edge(input bit wr, input logic [7:0] d, input bit done);
    int pre;
    pre = q.size();
    ovf_exp = 0;
    if (!on_line && pre > 0 && k >= ready_at) begin
      cur_byte = q.pop_front();
      on_line  = 1;
    end else if (on_line && done) begin
      on_line  = 0;
      ready_at = k + GAP + 1;
    end
    if (wr) begin
      if (pre < DEPTH) q.push_back(d);
      else ovf_exp = 1;
    end
  endtask

  task automatic check_all();
    chk("en",    32'(TX_En_Sig),  32'(on_line));
    chk("data",  32'(TX_Data),    32'(cur_byte));
    chk("cnt",   32'(Fifo_Cnt),   32'(q.size()));
    chk("full",  32'(Fifo_Full),  32'(q.size() == DEPTH));
    chk("empty", 32'(Fifo_Empty), 32'(q.size() == 0));
    chk("ovf",   32'(Wr_Ovf),     32'(ovf_exp));
    chk("busy",  32'(Busy),       32'(on_line || q.size() != 0 || (k + 1 < ready_at)));
  endtask

  task automatic step(input bit wr, input logic [7:0] d, input bit spur);
    Wr_En       = wr;
    Wr_Data     = d;
    TX_Done_Sig = ((stub_cnt >= STUB_LAT) && !hold) || spur;
    @(posedge sclk);
    #1;
    k++;
    model_edge(wr, d, TX_Done_Sig);
    check_all();
    stub_cnt = TX_En_Sig ? stub_cnt + 1 : 0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 8'h00, 0);
  endtask

  initial begin
    RST = 1'b1; Wr_En = 1'b0; Wr_Data = 8'h00; TX_Done_Sig = 1'b0;
    k = 0; stub_cnt = 0; hold = 0;
    model_reset();
    repeat (3) @(posedge sclk);
    #1;
    check_all();
    RST = 1'b0;

    // single byte: enable rises on the second edge after the write
    step(1, 8'h55, 0);
    chk("lat_edge1", 32'(TX_En_Sig), 32'd0);
    step(0, 8'h00, 0);
    chk("lat_edge2", 32'(TX_En_Sig), 32'd1);
    chk("lat_data",  32'(TX_Data),   32'h55);
    idle(20);
    chk("single_busy", 32'(Busy), 32'd0);

    // burst of three
    step(1, 8'hA5, 0);
    step(1, 8'h5A, 0);
    step(1, 8'hFF, 0);
    idle(50);

    // fill while tx_module stalls, then overflow
    hold = 1;
    for (int i = 0; i < DEPTH + 1; i++) step(1, 8'($urandom), 0);
    chk("fill_full", 32'(Fifo_Full), 32'd1);
    step(1, 8'hEE, 0);
    chk("ovf_pulse", 32'(Wr_Ovf), 32'd1);
    idle(3);

    // write while full in the same cycle the byte completes
    hold = 0;
    step(1, 8'hDD, 0);
    chk("ovf_done_same", 32'(Wr_Ovf), 32'd1);
    idle(DEPTH * (STUB_LAT + GAP + 2) + 20);

    // asynchronous reset mid-SEND
    step(1, 8'h11, 0);
    step(1, 8'h22, 0);
    idle(5);
    #2 RST = 1'b1;
    #1;
    model_reset();
    chk("rst_en",  32'(TX_En_Sig), 32'd0);
    chk("rst_cnt", 32'(Fifo_Cnt),  32'd0);
    chk("rst_data", 32'(TX_Data),  32'h00);
    stub_cnt = 0; Wr_En = 1'b0; TX_Done_Sig = 1'b0;
    @(posedge sclk);
    #1;
    k++;
    check_all();
    RST = 1'b0;
    step(1, 8'h3C, 0);
    idle(30);

    // spurious done in IDLE and in GAP
    step(0, 8'h00, 1);
    step(0, 8'h00, 1);
    step(1, 8'h96, 0);
    step(1, 8'h69, 1);
    idle(11);
    step(0, 8'h00, 1);
    step(0, 8'h00, 1);
    idle(40);

    // randomized traffic with stalls and stray done pulses
    for (int i = 0; i < 800; i++) begin
      if ($urandom_range(0, 49) == 0) hold = ~hold;
      step($urandom_range(0, 2) == 0, 8'($urandom), $urandom_range(0, 15) == 0);
    end
    hold = 0;
    idle(DEPTH * (STUB_LAT + GAP + 2) + 40);
    chk("final_idle", 32'(Busy), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
